// File: rtl/ofm_writeback.sv
// Output-feature-map writeback: buffers per-column conv sums, requantizes them and
// serializes the valid lanes onto one valid/ready stream tagged with the source column.
module ofm_writeback #(
    parameter int COL         = 8,
    parameter int OFM_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start_conv,
    input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
    input  logic                        cfg_relu,
    input  logic                        conv_done,
    input  logic [COL-1:0]              sum_valid,
    input  logic signed [OFM_WIDTH-1:0] sum [COL],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic [$clog2(COL)-1:0]      out_col,
    output logic                        overflow,
    output logic                        wb_done
);

    localparam int CW = $clog2(COL);
    localparam int AW = $clog2(DEPTH);

    typedef logic signed [OFM_WIDTH-1:0] sum_t;
    typedef logic signed [OFM_WIDTH:0]   ext_t;
    typedef logic signed [OUT_WIDTH-1:0] out_t;

    localparam ext_t SAT_HI  = ext_t'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam ext_t SAT_LO  = ext_t'(-(2 ** (OUT_WIDTH - 1)));
    localparam out_t OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam out_t OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // One extra bit of headroom so the rounding bias can never wrap.
    function automatic ext_t round_shift(input sum_t x, input logic [SHIFT_WIDTH-1:0] sh);
        ext_t xe;
        ext_t bias;
        xe = ext_t'(x);
        if (sh == '0) begin
            return xe;
        end
        bias = ext_t'(1) <<< (sh - SHIFT_WIDTH'(1));
        return (xe + bias) >>> sh;
    endfunction

    function automatic out_t saturate(input ext_t r);
        if (r > SAT_HI) begin
            return OUT_MAX;
        end
        if (r < SAT_LO) begin
            return OUT_MIN;
        end
        return out_t'(r[OUT_WIDTH-1:0]);
    endfunction

    function automatic out_t requant(input sum_t x, input logic [SHIFT_WIDTH-1:0] sh,
                                     input logic relu);
        ext_t r;
        r = round_shift(x, sh);
        if (relu && (r < 0)) begin
            r = '0;
        end
        return saturate(r);
    endfunction

    sum_t             fifo_sum_p0  [DEPTH][COL];
    logic [COL-1:0]   fifo_mask_p0 [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [CW-1:0]    lane_ptr;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic             relu_q;
    logic             done_pending;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   push_ok;
    logic                   drop;
    logic                   hs;
    logic                   pop;
    logic [COL-1:0]         head_mask;
    logic [CW-1:0]          sel_col;
    logic                   found;
    logic                   more;
    logic [SHIFT_WIDTH-1:0] eff_shift;
    logic                   eff_relu;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = |sum_valid;
    assign hs        = out_valid & out_ready;
    assign pop       = hs & ~more;
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign eff_shift = start_conv ? cfg_shift : shift_q;
    assign eff_relu  = start_conv ? cfg_relu  : relu_q;

    // p0: capture the whole column slice plus its lane mask as one entry
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < COL; i++) begin
                fifo_sum_p0[wr_ptr][i] <= sum[i];
            end
            fifo_mask_p0[wr_ptr] <= sum_valid;
        end
    end

    // p1: pick the next pending lane of the head entry; lanes below lane_ptr are already sent
    assign head_mask = fifo_mask_p0[rd_ptr];

    always_comb begin
        sel_col = '0;
        found   = 1'b0;
        more    = 1'b0;
        for (int i = 0; i < COL; i++) begin
            if (head_mask[i] && (i >= int'(lane_ptr))) begin
                if (!found) begin
                    found   = 1'b1;
                    sel_col = CW'(i);
                end else begin
                    more = 1'b1;
                end
            end
        end
    end

    // Gated so reset (which leaves storage untouched) shows zeros on the bus.
    assign out_valid = ~empty;
    assign out_col   = out_valid ? sel_col : '0;
    assign out_data  = out_valid ? requant(fifo_sum_p0[rd_ptr][sel_col], eff_shift, eff_relu)
                                 : '0;
    assign wb_done   = done_pending & empty & ~push;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lane_ptr     <= '0;
            shift_q      <= '0;
            relu_q       <= 1'b0;
            overflow     <= 1'b0;
            done_pending <= 1'b0;
        end else begin
            if (start_conv) begin
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                lane_ptr <= '0;
            end else if (hs) begin
                lane_ptr <= sel_col + CW'(1);
            end

            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (start_conv) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end

            // A fresh conv_done wins over the pulse it might coincide with.
            if (start_conv) begin
                done_pending <= 1'b0;
            end else if (conv_done) begin
                done_pending <= 1'b1;
            end else if (wb_done) begin
                done_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback: expected words are queued when sums are driven
// and checked in order as the DUT hands them off.
module tb_ofm_writeback;

    localparam int COL         = 8;
    localparam int OFM_WIDTH   = 32;
    localparam int OUT_WIDTH   = 8;
    localparam int SHIFT_WIDTH = 5;
    localparam int DEPTH       = 4;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        start_conv;
    logic [SHIFT_WIDTH-1:0]      cfg_shift;
    logic                        cfg_relu;
    logic                        conv_done;
    logic [COL-1:0]              sum_valid;
    logic signed [OFM_WIDTH-1:0] sum [COL];
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic [$clog2(COL)-1:0]      out_col;
    logic                        overflow;
    logic                        wb_done;

    typedef struct {
        int     col;
        longint data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ofm_writeback #(
        .COL(COL), .OFM_WIDTH(OFM_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .start_conv(start_conv), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .conv_done(conv_done), .sum_valid(sum_valid), .sum(sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .overflow(overflow), .wb_done(wb_done)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Floor-division reference for round-half-up shift, ReLU and 8-bit clamp.
    function automatic longint model(input longint x, input int sh, input bit relu);
        longint r;
        longint d;
        if (sh == 0) begin
            r = x;
        end else begin
            d = longint'(1) << sh;
            r = x + d / 2;
            r = (r >= 0) ? r / d : -((-r + d - 1) / d);
        end
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int col, input longint data);
        exp_t e;
        e.col  = col;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [COL-1:0] m, input longint v [COL]);
        sum_valid = m;
        for (int i = 0; i < COL; i++) sum[i] = OFM_WIDTH'(v[i]);
    endtask

    task automatic idle();
        sum_valid  = '0;
        conv_done  = 1'b0;
        start_conv = 1'b0;
    endtask

    task automatic start(input int sh, input bit relu);
        start_conv = 1'b1;
        cfg_shift  = SHIFT_WIDTH'(sh);
        cfg_relu   = relu;
        cyc();
        start_conv = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_valid === 1'b1) && n < 300) begin
            cyc();
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL extra_word col=%0d data=%0d expected no word", out_col, out_data);
            end else begin
                e = sb.pop_front();
                chk("word_col", out_col, e.col);
                chk("word_data", out_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        longint v [COL];
        int     pulses;
        int     first;
        int     n;
        bit     stalled;

        rstn = 1'b0; start_conv = 1'b0; cfg_shift = '0; cfg_relu = 1'b0;
        conv_done = 1'b0; sum_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < COL; i++) sum[i] = '0;
        cyc(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wb_done", wb_done, 0);
        rstn = 1'b1;
        cyc();

        // Basic: two lanes, one cycle latency, two accepted cycles
        start(4, 0);
        out_ready = 1'b1;
        foreach (v[i]) v[i] = 0;
        v[0] = 100; v[7] = -100;
        drive(8'h81, v);
        push_exp(0, 6); push_exp(7, -6);
        chk("basic_not_yet_valid", out_valid, 0);
        cyc(); idle();
        chk("basic_valid_next", out_valid, 1);
        chk("basic_first_col", out_col, 0);
        cyc(2);
        chk("basic_two_cycles", out_valid, 0);
        drain("basic_drain");

        // Rounding and saturation
        start(0, 0);
        foreach (v[i]) v[i] = 0;
        v[3] = 300;  drive(8'h08, v); push_exp(3, 127);  cyc();
        v[3] = -300; drive(8'h08, v); push_exp(3, -128); cyc();
        idle(); drain("sat_drain");
        start(1, 0);
        v[3] = 3;  drive(8'h08, v); push_exp(3, 2);  cyc();
        v[3] = -3; drive(8'h08, v); push_exp(3, -1); cyc();
        idle(); drain("round_drain");

        // ReLU on all-negative full mask
        start(2, 1);
        foreach (v[i]) v[i] = i - 8;
        drive(8'hFF, v);
        for (int i = 0; i < COL; i++) push_exp(i, 0);
        cyc(); idle(); drain("relu_drain");

        // Backpressure: fifth full entry is dropped
        start(3, 0);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            foreach (v[i]) v[i] = longint'($urandom_range(0, 4000)) - 2000;
            drive(8'hFF, v);
            if (k < DEPTH) for (int i = 0; i < COL; i++) push_exp(i, model(v[i], 3, 0));
            cyc();
        end
        idle();
        chk("ovf_set", overflow, 1);
        for (int s = 0; s < 3; s++) begin
            chk("stall_col", out_col, sb[0].col);
            chk("stall_data", out_data, sb[0].data);
            cyc();
        end
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            stalled = (out_valid === 1'b1) && !out_ready;
            cyc();
            n++;
            if (stalled && sb.size() != 0) begin
                chk("hold_col", out_col, sb[0].col);
                chk("hold_data", out_data, sb[0].data);
            end
        end
        out_ready = 1'b1;
        chk("full_drain", sb.size(), 0);
        cyc(2);
        chk("full_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        start(0, 0);
        chk("ovf_cleared", overflow, 0);

        // Completion: conv_done with the final push
        foreach (v[i]) v[i] = 0;
        v[0] = 11; v[1] = -12;
        drive(8'h03, v); push_exp(0, 11); push_exp(1, -12);
        cyc();
        v[0] = 7;
        drive(8'h01, v); push_exp(0, 7);
        conv_done = 1'b1;
        chk("done_not_early", wb_done, 0);
        cyc(); idle();
        pulses = 0; first = -1;
        for (int k = 0; k < 8; k++) begin
            if (wb_done === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            cyc();
        end
        chk("done_pulses", pulses, 1);
        chk("done_cycle", first, 2);
        chk("done_drain", sb.size(), 0);

        // Async reset with entries queued
        out_ready = 1'b0;
        foreach (v[i]) v[i] = 40 + i;
        drive(8'h0F, v); cyc();
        drive(8'h10, v); cyc();
        drive(8'hFF, v); cyc();
        idle();
        chk("pre_reset_valid", out_valid, 1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_col", out_col, 0);
        cyc(2);
        chk("rst_held_valid", out_valid, 0);
        rstn = 1'b1;
        out_ready = 1'b1;
        cyc(6);
        chk("no_stale_valid", out_valid, 0);
        cfg_shift = 5'd7;
        foreach (v[i]) v[i] = 0;
        v[2] = 5;
        drive(8'h04, v); push_exp(2, 5);
        cyc(); idle();
        drain("post_reset_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofm_writeback.md
Name: ofm_writeback

Overview:
- Sits directly downstream of the 3x3 conv kernel top.
- Captures the COL-wide per-column `sum_valid`/`sum` output each cycle into a small entry FIFO.
- Requantizes each captured partial sum: rounding arithmetic shift, optional ReLU, signed saturation.
- Serializes the valid lanes onto a single valid/ready output stream tagged with column index, and pulses `wb_done` once the kernel has signalled `conv_done` and all captured data has drained.

Parameters:
- COL, 8, number of PE columns / sum lanes.
- OFM_WIDTH, 32, signed width of each incoming sum.
- OUT_WIDTH, 8, signed width of requantized output.
- SHIFT_WIDTH, 5, width of shift configuration.
- DEPTH, 4, entry FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start_conv  in  1  start pulse; latches configuration, clears sticky status.
- cfg_shift  in  SHIFT_WIDTH  requant right-shift amount (0..OFM_WIDTH-1).
- cfg_relu  in  1  1 = clamp negatives to 0.
- conv_done  in  1  kernel completion pulse.
- sum_valid  in  COL  per-lane valid of current sums.
- sum  in  COL x OFM_WIDTH  unpacked array of signed sums (sum_t), lane i = column i.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts word.
- out_data  out  OUT_WIDTH  requantized signed value.
- out_col  out  $clog2(COL)  source column of out_data.
- overflow  out  1  sticky: a sum entry was dropped.
- wb_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_col=0, overflow=0, wb_done=0. FIFO empty, lane pointer 0, done_pending=0, cfg regs 0.
- Effective cfg = start_conv ? cfg_* inputs : latched regs. Regs load on start_conv. Cfg is applied at emission time.
- Push condition: |sum_valid. Stores all COL sums plus the sum_valid mask as one entry.
- Full handling:
  - Push while full with no pop in the same cycle: entry dropped, overflow set.
  - Push while full with a pop in the same cycle: accepted.
  - overflow clears only on start_conv or reset.
- Output stream:
  - out_valid=1 when FIFO non-empty.
  - out_col = lowest set mask bit of head entry at index >= lane pointer.
  - out_data = requant(head.sum[out_col]), combinational from head and pointer.
  - Latency: sums pushed in cycle N give out_valid in cycle N+1.
- Handshake (out_valid & out_ready):
  - Clear that mask bit.
  - If no higher set bit remains, pop the entry and reset the pointer to 0.
  - Otherwise advance the pointer past out_col.
  - Throughput is one lane per cycle; an entry with k valid lanes occupies k accepted cycles.
  - out_data/out_col must hold stable while out_valid=1 and out_ready=0.
- Requant, computed at OFM_WIDTH+1 bits:
  - shift=0: r=x.
  - shift>0: r = (x + 2^(shift-1)) >>> shift, arithmetic.
  - If relu and r<0: r=0.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Completion:
  - conv_done sets done_pending; this includes conv_done in the same cycle as the final push.
  - wb_done pulses the first cycle in which done_pending=1, FIFO empty, and no push occurs; done_pending clears in that cycle.
  - start_conv clears done_pending.
- Usage rule: start_conv is issued only after wb_done. Otherwise the block keeps FIFO contents and applies the new cfg to them.
- Async reset mid-operation: FIFO discarded, all outputs return to reset values immediately.

Test Plan:
- Basic: shift=4, relu=0, mask=0x81, sum[0]=100, sum[7]=-100 -> out_valid next cycle; words (col0, 6) then (col7, -6); 2 cycles with out_ready=1.
- Rounding/saturation: shift=0, sum[3]=300 -> 127. sum[3]=-300 -> -128. shift=1, sum=3 -> 2. shift=1, sum=-3 -> -1.
- ReLU: relu=1, shift=2, lanes 0..7 = -8..-1 all valid -> eight words of value 0, cols 0..7 in order.
- Backpressure/full: out_ready=0, five consecutive full-mask pushes with DEPTH=4 -> 4th accepted, 5th dropped, overflow=1. Release -> 32 words, out_data/out_col stable during stall. overflow stays 1 until start_conv.
- Done: conv_done in the same cycle as the last push (mask 0x01) -> wb_done pulses exactly once, in the cycle after that word's handshake.
- Reset mid-stream: rstn low with 3 entries queued -> out_valid=0 during reset; no stale words after release.
